riscv_mc_sequencer: RTL and testbench

- Multi-cycle control FSM that drives the RV32I core's shared datapath: fetch, decode, execute, memory, writeback.
- Owns the PC and the instruction register (IR), and handshakes with the instruction and data memories.
- Feeds the IR to the combinational decoder and consumes the decoder's branch/jump flags and the datapath's branch-condition and target results.
- Gates the register-file write so that it happens exactly once per instruction.

---
 rtl/riscv_seq_pkg.sv | 45 ++++
 rtl/riscv_seq_timeout.sv | 33 +++
 rtl/riscv_mc_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_riscv_mc_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_seq_pkg;

  // FSM states; the encodings are visible on the state output.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  // Trap cause codes, latched once on entry to TRAP.
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  // RV32I major opcodes (ir[6:0]).
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // True for every opcode the core implements; anything else traps.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/riscv_seq_timeout.sv
// Memory-wait cycle counter shared by the FETCH and MEM states.
// Latency: expired is combinational from the count register.
// Backpressure: none; counts while en is high, clr has priority.
module riscv_seq_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count wait cycles; expired flags the last permitted wait cycle so the
  // FSM leaves after exactly TIMEOUT request cycles without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RV32I control FSM: owns PC/IR, sequences fetch/decode/exec/mem/wb.
// Latency: ALU 4, branch 3, load 5, store 4 cycles with zero-wait memories.
// Backpressure: requests held until ack; TIMEOUT waits trap. RISCV_SEQ_PERF_EN adds perf counters.
module riscv_mc_sequencer
  import riscv_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_reg_write,
  input  logic        dec_is_branch,
  input  logic        dec_is_jmp,
  input  logic        dec_is_jmpr,
  input  logic        branch_cond,
  input  logic [31:0] tgt_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef RISCV_SEQ_PERF_EN
  ,
  output logic [63:0] perf_cycles,
  output logic [63:0] perf_instret
`endif
);

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] ir_q;
  logic [31:0] tgt_q;
  logic        jmp_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        rf_we_q;
  logic [1:0]  cause_q;
  logic [1:0]  cause_nxt;
  logic        ir_load;
  logic        tgt_load;
  logic        wait_en;
  logic        wait_clr;
  logic        expired;
  logic [6:0]  opcode;
  logic [31:0] pc_inc;

  assign opcode = ir_q[6:0];
  assign pc_inc = pc_q + 32'd4;

  // A wait cycle is a request cycle without its ack; only these advance the counter.
  assign wait_en  = ((cur_state == ST_FETCH) && imem_req_q && !imem_ack) ||
                    ((cur_state == ST_MEM)   && dmem_req_q && !dmem_ack);
  assign wait_clr = (nxt_state != cur_state);

  riscv_seq_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and datapath-update decisions; acks only count in the matching waiting state.
  always_comb begin
    nxt_state = cur_state;
    pc_nxt    = pc_q;
    ir_load   = 1'b0;
    tgt_load  = 1'b0;
    cause_nxt = CAUSE_NONE;
    case (cur_state)
      ST_FETCH: begin
        // The cycle right after reset has no request out yet, so a stray ack is ignored.
        if (imem_req_q) begin
          if (imem_ack) begin
            ir_load   = 1'b1;
            nxt_state = ST_DECODE;
          end else if (expired) begin
            nxt_state = ST_TRAP;
            cause_nxt = CAUSE_TIMEOUT;
          end
        end
      end
      ST_DECODE: begin
        if (is_legal_op(opcode)) begin
          nxt_state = ST_EXEC;
        end else begin
          nxt_state = ST_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (dec_is_branch) begin
          if (branch_cond && (tgt_addr[1:0] != 2'b00)) begin
            nxt_state = ST_TRAP;
            cause_nxt = CAUSE_MISALIGN;
          end else begin
            pc_nxt    = branch_cond ? tgt_addr : pc_inc;
            nxt_state = ST_FETCH;
          end
        end else if (dec_is_jmp || dec_is_jmpr) begin
          if (tgt_addr[1:0] != 2'b00) begin
            nxt_state = ST_TRAP;
            cause_nxt = CAUSE_MISALIGN;
          end else begin
            tgt_load  = 1'b1;
            nxt_state = ST_WB;
          end
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          nxt_state = ST_MEM;
        end else begin
          nxt_state = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_req_q) begin
          if (dmem_ack) begin
            if (opcode == OP_STORE) begin
              pc_nxt    = pc_inc;
              nxt_state = ST_FETCH;
            end else begin
              nxt_state = ST_WB;
            end
          end else if (expired) begin
            nxt_state = ST_TRAP;
            cause_nxt = CAUSE_TIMEOUT;
          end
        end
      end
      ST_WB: begin
        pc_nxt    = jmp_q ? tgt_q : pc_inc;
        nxt_state = ST_FETCH;
      end
      ST_TRAP: begin
        nxt_state = ST_TRAP;
      end
      default: begin
        nxt_state = ST_TRAP;
        cause_nxt = CAUSE_ILLEGAL;
      end
    endcase
  end

  // PC, IR and jump-target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      tgt_q <= '0;
      jmp_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (ir_load) begin
        ir_q <= imem_rdata;
      end
      if (tgt_load) begin
        tgt_q <= tgt_addr;
      end
      if (cur_state == ST_EXEC) begin
        jmp_q <= tgt_load;
      end
    end
  end

  // Strobes are registered from the next state so no ack reaches a request combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      imem_req_q <= (nxt_state == ST_FETCH);
      dmem_req_q <= (nxt_state == ST_MEM);
      dmem_we_q  <= (nxt_state == ST_MEM) && (opcode == OP_STORE);
      rf_we_q    <= (nxt_state == ST_WB) && dec_reg_write;
    end
  end

  // Trap cause is captured once on entry and then held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= CAUSE_NONE;
    end else if ((cur_state != ST_TRAP) && (nxt_state == ST_TRAP)) begin
      cause_q <= cause_nxt;
    end
  end

`ifdef RISCV_SEQ_PERF_EN
  // Cycle and retired-instruction counters; both wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_instret <= '0;
    end else begin
      if (cur_state != ST_TRAP) begin
        perf_cycles <= perf_cycles + 64'd1;
      end
      if ((nxt_state == ST_FETCH) &&
          ((cur_state == ST_EXEC) || (cur_state == ST_MEM) || (cur_state == ST_WB))) begin
        perf_instret <= perf_instret + 64'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_inc;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign rf_we      = rf_we_q;
  assign state      = cur_state;
  assign trap       = (cur_state == ST_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Directed self-checking bench for riscv_mc_sequencer.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench plays the memories, delaying acks where needed.
module tb_riscv_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic        dec_reg_write = 1'b0;
  logic        dec_is_branch = 1'b0;
  logic        dec_is_jmp = 1'b0;
  logic        dec_is_jmpr = 1'b0;
  logic        branch_cond = 1'b0;
  logic [31:0] tgt_addr = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef RISCV_SEQ_PERF_EN
  logic [63:0] perf_cycles;
  logic [63:0] perf_instret;
`endif

  int total = 0;
  int passed = 0;
  int fails = 0;
  int n_req;

  riscv_mc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir            (ir),
    .dec_reg_write (dec_reg_write),
    .dec_is_branch (dec_is_branch),
    .dec_is_jmp    (dec_is_jmp),
    .dec_is_jmpr   (dec_is_jmpr),
    .branch_cond   (branch_cond),
    .tgt_addr      (tgt_addr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .rf_we         (rf_we),
    .state         (state),
    .trap          (trap),
    .trap_cause    (trap_cause)
`ifdef RISCV_SEQ_PERF_EN
    ,
    .perf_cycles   (perf_cycles),
    .perf_instret  (perf_instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic rw, input logic br, input logic j, input logic jr);
    dec_reg_write = rw;
    dec_is_branch = br;
    dec_is_jmp    = j;
    dec_is_jmpr   = jr;
  endtask

  // Zero-wait fetch: must be sitting in FETCH with the request out.
  task automatic fetch(input logic [31:0] instr, input logic [31:0] exp_pc);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // Reset values.
    #12;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_strobes", {29'd0, dmem_req, dmem_we, rf_we}, 32'd0);
    chk("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // ADD: F, D, E, W then back to FETCH at pc 4.
    set_dec(1'b1, 1'b0, 1'b0, 1'b0);
    fetch(32'h0020_81B3, 32'h0);
    chk("add_dec_state", {29'd0, state}, 32'd1);
    chk("add_ir", ir, 32'h0020_81B3);
    chk("add_req_drop", {31'd0, imem_req}, 32'd0);
    step();
    chk("add_exec_state", {29'd0, state}, 32'd2);
    chk("add_exec_rfwe", {31'd0, rf_we}, 32'd0);
    step();
    chk("add_wb_state", {29'd0, state}, 32'd4);
    chk("add_wb_rfwe", {31'd0, rf_we}, 32'd1);
    step();
    chk("add_pc", pc, 32'h4);
    chk("add_rfwe_off", {31'd0, rf_we}, 32'd0);

    // BEQ taken to 0x40.
    set_dec(1'b0, 1'b1, 1'b0, 1'b0);
    branch_cond = 1'b1;
    tgt_addr    = 32'h40;
    fetch(32'h0020_8063, 32'h4);
    step();
    chk("beq_t_rfwe", {31'd0, rf_we}, 32'd0);
    step();
    chk("beq_t_state", {29'd0, state}, 32'd0);
    chk("beq_t_pc", pc, 32'h40);

    // BEQ not taken: pc advances by 4.
    branch_cond = 1'b0;
    tgt_addr    = 32'h80;
    fetch(32'h0020_8063, 32'h40);
    step();
    step();
    chk("beq_nt_pc", pc, 32'h44);
    chk("beq_nt_rfwe", {31'd0, rf_we}, 32'd0);

    // LW with the data ack arriving in the 4th request cycle.
    set_dec(1'b1, 1'b0, 1'b0, 1'b0);
    fetch(32'h0000_A183, 32'h44);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("lw_dreq", {30'd0, dmem_req, dmem_we}, 32'd2);
      if (i == 3) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    chk("lw_wb_state", {29'd0, state}, 32'd4);
    chk("lw_wb", {30'd0, rf_we, dmem_req}, 32'd2);
    step();
    chk("lw_pc", pc, 32'h48);

    // SW: store strobe, no register write, pc advances from MEM.
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    fetch(32'h0020_A023, 32'h48);
    step();
    step();
    chk("sw_dreq", {30'd0, dmem_req, dmem_we}, 32'd3);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sw_state", {29'd0, state}, 32'd0);
    chk("sw_pc", pc, 32'h4C);
    chk("sw_rfwe", {31'd0, rf_we}, 32'd0);

    // JAL to 0x100, link value is pc+4.
    set_dec(1'b1, 1'b0, 1'b1, 1'b0);
    tgt_addr = 32'h100;
    fetch(32'h0080_00EF, 32'h4C);
    step();
    step();
    chk("jal_wb_rfwe", {31'd0, rf_we}, 32'd1);
    chk("jal_link", pc_plus4, 32'h50);
    step();
    chk("jal_pc", pc, 32'h100);

    // JAL to the top word, then an ALU op wraps pc to 0.
    tgt_addr = 32'hFFFF_FFFC;
    fetch(32'h0080_00EF, 32'h100);
    step();
    step();
    step();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);

    // ADD with stray acks in DECODE/EXEC, which must be ignored.
    set_dec(1'b1, 1'b0, 1'b0, 1'b0);
    fetch(32'h0020_81B3, 32'hFFFF_FFFC);
    imem_ack   = 1'b1;
    dmem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step();
    chk("stray_ir", ir, 32'h0020_81B3);
    chk("stray_state", {29'd0, state}, 32'd2);
    step();
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    imem_rdata = '0;
    chk("stray_wb_state", {29'd0, state}, 32'd4);
    step();
    chk("wrap_add_pc", pc, 32'h0);
    chk("wrap_no_trap", {31'd0, trap}, 32'd0);

    // JALR to a misaligned target traps with cause 2, no register write.
    set_dec(1'b1, 1'b0, 1'b0, 1'b1);
    tgt_addr = 32'h102;
    fetch(32'h0000_80E7, 32'h0);
    step();
    chk("jalr_exec_rfwe", {31'd0, rf_we}, 32'd0);
    step();
    chk("jalr_state", {29'd0, state}, 32'd7);
    chk("jalr_trap", {29'd0, trap, trap_cause}, 32'd6);
    step();
    step();
    chk("jalr_rfwe", {31'd0, rf_we}, 32'd0);
    chk("jalr_pc_frozen", pc, 32'h0);

    // Illegal opcode traps with cause 1; later fetch acks change nothing.
    do_reset();
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst2_cause", {30'd0, trap_cause}, 32'd0);
    fetch(32'h0000_007F, 32'h0);
    step();
    chk("ill_state", {29'd0, state}, 32'd7);
    chk("ill_trap", {29'd0, trap, trap_cause}, 32'd5);
    chk("ill_req", {31'd0, imem_req}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0020_81B3;
    step();
    step();
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("ill_ir_frozen", ir, 32'h0000_007F);
    chk("ill_sticky", {26'd0, state, trap, trap_cause}, 32'h3D);

    // Reset in the middle of a fetch wait drops the request at once.
    do_reset();
    set_dec(1'b1, 1'b0, 1'b0, 1'b0);
    fetch(32'h0020_81B3, 32'h0);
    step();
    step();
    step();
    chk("pre_wait_pc", pc, 32'h4);
    for (int i = 0; i < 5; i++) step();
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // No fetch ack ever: trap after exactly 16 request cycles.
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (state == 3'd7) break;
      if (imem_req) n_req = n_req + 1;
      step();
    end
    chk("to_req_cycles", n_req, 32'd16);
    chk("to_state", {29'd0, state}, 32'd7);
    chk("to_trap", {29'd0, trap, trap_cause}, 32'd7);
    chk("to_req_off", {31'd0, imem_req}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
